button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable-sample count required to accept a level change; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 btn_in  input  1  raw asynchronous push-button or switch level.
REQ-005 btn_level  output  1  debounced level; drives the downstream D flip-flop's D input.
REQ-006 btn_rise  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-007 btn_fall  output  1  one-cycle pulse on an accepted 1->0 change.

Function
REQ-008 btn_in SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other logic uses it; only sync2 is observed by the FSM.
REQ-009 FSM SHALL have exactly four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-010 STABLE_LOW: if sync2=1, go to WAIT_HIGH with count cleared to 0; else remain.
REQ-011 WAIT_HIGH: if sync2=0, return to STABLE_LOW (bounce rejected, no output change); else if count = DEBOUNCE_CYCLES-1, go to STABLE_HIGH; else increment count.
REQ-012 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-010/011 with polarities inverted.
REQ-013 Count SHALL be 16 bits unsigned, SHALL never wrap, and SHALL be held at 0 in both STABLE states.
REQ-014 btn_level SHALL be registered and SHALL equal 1 exactly when the state is STABLE_HIGH or WAIT_LOW.
REQ-015 btn_rise SHALL be asserted for exactly one cycle, registered, on the same edge that enters STABLE_HIGH.
REQ-016 btn_fall SHALL be asserted for exactly one cycle, registered, on the same edge that enters STABLE_LOW from WAIT_LOW.
REQ-017 btn_rise and btn_fall SHALL never be asserted in the same cycle; neither SHALL be asserted on a bounce return (WAIT_x -> STABLE_x same side).
REQ-018 Latency: if btn_in is high before rising edge k and remains high, btn_level and btn_rise SHALL become 1 immediately after edge k+DEBOUNCE_CYCLES+2. Falling direction SHALL be symmetric.
REQ-019 A single-cycle reversal of sync2 at any point during WAIT_x SHALL restart the acceptance window from zero on the next qualifying edge.
REQ-020 The block SHALL be fully synchronous: no combinational path from btn_in to any output.

Reset
REQ-021 While rst_n=0 at a rising edge: sync1=0, sync2=0, state=STABLE_LOW, count=0, btn_level=0, btn_rise=0, btn_fall=0.
REQ-022 Reset asserted mid-WAIT_HIGH or mid-STABLE_HIGH SHALL abort immediately; no btn_rise or btn_fall pulse SHALL be emitted due to reset.
REQ-023 After rst_n returns to 1 with btn_in already high, the block SHALL treat this as a new rising change and obey REQ-018 timing, measured from the first edge with rst_n=1.
REQ-024 Asynchronous deassertion of rst_n between edges SHALL have no effect until the next rising edge.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-025 Clean press: btn_in 0->1 before edge 0 and held -> btn_level=1 and btn_rise=1 after edge 6; btn_rise=0 after edge 7.
REQ-026 Bounce: btn_in high for 3 cycles, low for 1 cycle, then held high -> no pulse during the glitch; btn_rise fires exactly once, 6 edges after the final 0->1 reaches btn_in.
REQ-027 Short glitch: btn_in high for 2 cycles, then low -> btn_level stays 0; btn_rise never asserts.
REQ-028 Release: from STABLE_HIGH, btn_in 1->0 held -> btn_fall=1 and btn_level=0 after edge 6; single pulse only.
REQ-029 Reset mid-window: btn_in held high, rst_n=0 at edge 4 for one cycle -> all outputs 0; no pulse; btn_rise fires 6 edges after the first edge with rst_n=1.
REQ-030 Long hold: btn_in held high for 70000 cycles with DEBOUNCE_CYCLES=65535 -> exactly one btn_rise; count never wraps; btn_level remains 1.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state acceptance FSM.
// The level changes only after DEBOUNCE_CYCLES consecutive stable samples; edges pulse once.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  typedef enum logic [1:0] {
    StStableLow  = 2'd0,
    StWaitHigh   = 2'd1,
    StStableHigh = 2'd2,
    StWaitLow    = 2'd3
  } state_e;

  // Last count value of the acceptance window; the window never reaches the counter's wrap point.
  localparam logic [15:0] CountLast = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  state_e      r_state;
  logic [15:0] r_count;
  logic        r_level;
  logic        r_rise;
  logic        r_fall;

  state_e      w_state_next;
  logic [15:0] w_count_next;
  logic        w_level_next;
  logic        w_rise_next;
  logic        w_fall_next;

  always_comb begin
    w_state_next = r_state;
    w_count_next = 16'd0;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    unique case (r_state)
      StStableLow: begin
        if (r_sync2) w_state_next = StWaitHigh;
      end
      StWaitHigh: begin
        if (!r_sync2) begin
          w_state_next = StStableLow;
        end else if (r_count == CountLast) begin
          w_state_next = StStableHigh;
          w_rise_next  = 1'b1;
        end else begin
          w_count_next = r_count + 16'd1;
        end
      end
      StStableHigh: begin
        if (!r_sync2) w_state_next = StWaitLow;
      end
      StWaitLow: begin
        if (r_sync2) begin
          w_state_next = StStableHigh;
        end else if (r_count == CountLast) begin
          w_state_next = StStableLow;
          w_fall_next  = 1'b1;
        end else begin
          w_count_next = r_count + 16'd1;
        end
      end
      default: begin
        w_state_next = StStableLow;
      end
    endcase
    w_level_next = (w_state_next == StStableHigh) || (w_state_next == StWaitLow);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= StStableLow;
      r_count <= 16'd0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: short window instance plus a maximum-window instance.
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_long;
  logic long_level;
  logic long_rise;
  logic long_fall;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int both_cnt = 0;
  int base_r;
  int base_f;
  int long_rises;
  int long_at;

  button_debouncer #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(65535)) u_dut_long (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_long),
    .btn_level (long_level),
    .btn_rise  (long_rise),
    .btn_fall  (long_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_rise) rise_cnt <= rise_cnt + 1;
    if (btn_fall) fall_cnt <= fall_cnt + 1;
    if (btn_rise && btn_fall) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each step advances past one rising edge and settles 1 time unit after it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_in   = 1'b0;
    btn_long = 1'b0;
    step(3);
    check_eq("reset_level", 32'(btn_level), 32'd0);
    check_eq("reset_rise", 32'(btn_rise), 32'd0);
    check_eq("reset_fall", 32'(btn_fall), 32'd0);
    rst_n = 1'b1;
    step(3);
    check_eq("idle_level", 32'(btn_level), 32'd0);

    // Clean press: high before edge 0, accepted right after edge 6.
    base_r = rise_cnt;
    btn_in = 1'b1;
    step(6);
    check_eq("press_level_early", 32'(btn_level), 32'd0);
    step(1);
    check_eq("press_level", 32'(btn_level), 32'd1);
    check_eq("press_rise", 32'(btn_rise), 32'd1);
    step(1);
    check_eq("press_rise_clear", 32'(btn_rise), 32'd0);
    check_eq("press_level_hold", 32'(btn_level), 32'd1);
    step(5);
    check_eq("press_rise_count", 32'(rise_cnt - base_r), 32'd1);

    // Release from stable high.
    base_f = fall_cnt;
    base_r = rise_cnt;
    btn_in = 1'b0;
    step(6);
    check_eq("release_level_early", 32'(btn_level), 32'd1);
    check_eq("release_fall_early", 32'(btn_fall), 32'd0);
    step(1);
    check_eq("release_fall", 32'(btn_fall), 32'd1);
    check_eq("release_level", 32'(btn_level), 32'd0);
    step(1);
    check_eq("release_fall_clear", 32'(btn_fall), 32'd0);
    step(5);
    check_eq("release_fall_count", 32'(fall_cnt - base_f), 32'd1);
    check_eq("release_no_rise", 32'(rise_cnt - base_r), 32'd0);

    // Bounce: 3 high, 1 low, then held; acceptance 6 edges after the final 0->1.
    base_r = rise_cnt;
    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    step(1);
    btn_in = 1'b1;
    step(6);
    check_eq("bounce_level_early", 32'(btn_level), 32'd0);
    check_eq("bounce_no_pulse", 32'(rise_cnt - base_r), 32'd0);
    step(1);
    check_eq("bounce_level", 32'(btn_level), 32'd1);
    check_eq("bounce_rise", 32'(btn_rise), 32'd1);
    step(6);
    check_eq("bounce_rise_count", 32'(rise_cnt - base_r), 32'd1);
    btn_in = 1'b0;
    step(12);
    check_eq("bounce_release_level", 32'(btn_level), 32'd0);

    // Short glitch of two cycles is rejected.
    base_r = rise_cnt;
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(12);
    check_eq("glitch_level", 32'(btn_level), 32'd0);
    check_eq("glitch_rise_count", 32'(rise_cnt - base_r), 32'd0);

    // Reset mid-window at edge 4; rise 6 edges after the first edge with rst_n=1.
    base_r = rise_cnt;
    base_f = fall_cnt;
    btn_in = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    check_eq("rstwin_level", 32'(btn_level), 32'd0);
    check_eq("rstwin_rise", 32'(btn_rise), 32'd0);
    check_eq("rstwin_fall", 32'(btn_fall), 32'd0);
    rst_n = 1'b1;
    step(6);
    check_eq("rstwin_level_early", 32'(btn_level), 32'd0);
    check_eq("rstwin_no_pulse", 32'(rise_cnt - base_r), 32'd0);
    step(1);
    check_eq("rstwin_level", 32'(btn_level), 32'd1);
    check_eq("rstwin_rise_after", 32'(btn_rise), 32'd1);
    step(3);

    // Reset while stable high: drops level without a fall pulse, then re-accepts.
    base_r = rise_cnt;
    rst_n = 1'b0;
    step(1);
    check_eq("rsthi_level", 32'(btn_level), 32'd0);
    check_eq("rsthi_fall", 32'(btn_fall), 32'd0);
    rst_n = 1'b1;
    step(1);
    check_eq("rsthi_no_fall", 32'(fall_cnt - base_f), 32'd0);
    step(5);
    check_eq("rsthi_level_early", 32'(btn_level), 32'd0);
    step(1);
    check_eq("rsthi_relevel", 32'(btn_level), 32'd1);
    check_eq("rsthi_rerise", 32'(btn_rise), 32'd1);
    btn_in = 1'b0;
    step(12);
    check_eq("rsthi_final_level", 32'(btn_level), 32'd0);
    check_eq("rise_fall_overlap", 32'(both_cnt), 32'd0);

    // Maximum window: one rise after edge 65537, counted as step 65538.
    long_rises = 0;
    long_at    = 0;
    btn_long   = 1'b1;
    for (int i = 1; i <= 70000; i++) begin
      step(1);
      if (long_rise) begin
        long_rises++;
        long_at = i;
      end
    end
    check_eq("long_rise_count", 32'(long_rises), 32'd1);
    check_eq("long_rise_step", 32'(long_at), 32'd65538);
    check_eq("long_level", 32'(long_level), 32'd1);
    check_eq("long_fall", 32'(long_fall), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
